move_sched: RTL and testbench
=============================

MOVE_SCHED -- requirements
Module: move_sched

Interface
REQ-001 Parameter TICK_BASE, default 2500000, base step period in clk_25M cycles (100 ms).
REQ-002 Parameter CNT_W, default 24, width of the tick counter; it SHALL hold TICK_BASE*4-1.
REQ-003 clk_25M  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 key_stroke  input  3  registered key code: 000 UP, 001 DOWN, 010 LEFT, 011 RIGHT, 100 PAUSE; other codes ignored.
REQ-006 speed  input  2  step-rate select, sampled at each period start.
REQ-007 game_over  input  1  level from the collision logic; terminates play.
REQ-008 step_ack  input  1  snake datapath accepted the current step.
REQ-009 step_req  output  1  request one snake move in direction dir.
REQ-010 dir  output  2  committed direction, same encoding as key_stroke[1:0].
REQ-011 paused  output  1  high while in PAUSED state.
REQ-012 step_count  output  16  number of completed steps, wraps modulo 2^16.

Function
REQ-013 FSM states: RUN, WAIT_ACK, PAUSED, OVER; exactly one active.
REQ-014 Period P = TICK_BASE*(4-speed): speed 0 slowest (4x), speed 3 fastest (1x).
REQ-015 RUN: tick counter increments each cycle; at count P-1, next cycle step_req=1, dir<=pending_dir, counter<=0, state WAIT_ACK.
REQ-016 speed SHALL be latched when counter is 0; mid-period changes take effect next period.
REQ-017 WAIT_ACK: step_req held high, dir held stable, counter frozen at 0 until step_ack=1.
REQ-018 step_ack=1 in WAIT_ACK: next cycle step_req=0, step_count+1, state RUN (or PAUSED per REQ-022); step_ack outside WAIT_ACK ignored.
REQ-019 pending_dir updates every cycle key_stroke is a direction code and not the opposite of dir (opposite = same bit1, different bit0); opposite codes discarded, pending_dir unchanged.
REQ-020 Reversal check SHALL use committed dir, not pending_dir: RIGHT committed, UP then LEFT within one period -> pending stays UP.
REQ-021 RUN with key_stroke=PAUSE: next cycle state PAUSED; counter frozen, not cleared.
REQ-022 WAIT_ACK with key_stroke=PAUSE: request SHALL NOT be withdrawn; on step_ack go to PAUSED instead of RUN.
REQ-023 PAUSED: leave to RUN the cycle after key_stroke becomes a direction code; counting resumes from the frozen value; the direction code is filtered per REQ-019.
REQ-024 game_over=1 in any state: next cycle state OVER, step_req=0, counter 0; WAIT_ACK step abandoned, step_count not incremented.
REQ-025 OVER: absorbing; only rst exits; key_stroke, speed, step_ack ignored.
REQ-026 Priority in one cycle: game_over > step_ack > PAUSE > tick expiry.
REQ-027 step_req SHALL be a registered output with no combinational path from any input.

Reset
REQ-028 rst=1: state RUN, step_req=0, dir=RIGHT (11), pending_dir=RIGHT, paused=0, step_count=0, counter=0, latched speed=0.
REQ-029 rst asserted mid-handshake SHALL drop step_req immediately (asynchronously) with no step counted.
REQ-030 First step after rst release SHALL issue exactly P cycles after release, with P from the speed value present on the first cycle after release.

Verification (TICK_BASE=4)
REQ-031 speed=3, key_stroke=RIGHT, step_ack tied high -> step_req pulses every 5 cycles (4 count + 1 handshake), dir=11, step_count=1,2,3.
REQ-032 speed=0, step_ack low -> step_req rises after 16 cycles and stays high with dir stable for 20 cycles; ack at cycle 20 -> step_req low next cycle, step_count=1.
REQ-033 dir=RIGHT, key_stroke UP then LEFT within one period -> next step dir=00; key LEFT alone -> dir stays 11.
REQ-034 key_stroke=PAUSE at counter 2 -> paused=1, no step_req for 50 cycles; key DOWN -> paused=0, step issued 2 cycles later with dir=01.
REQ-035 PAUSE during WAIT_ACK -> step_req held until ack, then paused=1, step_count incremented once.
REQ-036 game_over pulse during WAIT_ACK -> step_req=0 next cycle, step_count unchanged, no further requests until rst; rst -> dir=11, step_count=0.

Source files
------------

// File: rtl/move_sched_if.sv
// Handshake and status bundle between the move scheduler and its
// surroundings (key decoder, speed selector, collision logic, snake datapath).
interface move_sched_if;
  logic [2:0]  key_stroke;
  logic [1:0]  speed;
  logic        game_over;
  logic        step_ack;
  logic        step_req;
  logic [1:0]  dir;
  logic        paused;
  logic [15:0] step_count;

  // Driver side: game control and datapath feeding the scheduler.
  modport master (
    output key_stroke, speed, game_over, step_ack,
    input  step_req, dir, paused, step_count
  );

  // Scheduler side.
  modport slave (
    input  key_stroke, speed, game_over, step_ack,
    output step_req, dir, paused, step_count
  );
endinterface

// File: rtl/move_sched.sv
// Snake move scheduler: paces step requests at a speed-dependent period,
// filters direction keys against reversal, handles pause and game over.
module move_sched #(
  parameter int unsigned TICK_BASE = 2500000,
  parameter int unsigned CNT_W     = 24
) (
  input logic         clk_25M,
  input logic         rst,
  move_sched_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_ACK = 2'd1,
    PAUSED   = 2'd2,
    OVER     = 2'd3
  } state_t;

  localparam logic [2:0] KEY_PAUSE = 3'b100;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       spd_q, spd_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       pend_q, pend_d;
  logic             req_q, req_d;
  logic [15:0]      scnt_q, scnt_d;
  logic             pause_pend_q, pause_pend_d;

  logic             key_is_dir;
  logic             key_is_pause;
  logic             key_accept;
  logic [1:0]       spd_eff;

  // Last counter value of a period: TICK_BASE*(4-speed) - 1.
  function automatic logic [CNT_W-1:0] last_count(input logic [1:0] spd);
    logic [31:0] per;
    per = TICK_BASE * (32'd4 - {30'd0, spd});
    return per[CNT_W-1:0] - CNT_W'(1);
  endfunction

  // Key classification; reversal is judged against the committed direction
  // so two quick keys cannot sneak the snake into itself.
  always_comb begin
    key_is_dir   = (bus.key_stroke[2] == 1'b0);
    key_is_pause = (bus.key_stroke == KEY_PAUSE);
    key_accept   = key_is_dir &&
                   !((bus.key_stroke[1] == dir_q[1]) &&
                     (bus.key_stroke[0] != dir_q[0]));
    // At period start the live speed applies, so the very first period after
    // reset already uses the requested rate.
    spd_eff      = (cnt_q == '0) ? bus.speed : spd_q;
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    spd_d        = spd_q;
    dir_d        = dir_q;
    pend_d       = pend_q;
    req_d        = req_q;
    scnt_d       = scnt_q;
    pause_pend_d = pause_pend_q;

    if ((state_q != OVER) && key_accept) begin
      pend_d = bus.key_stroke[1:0];
    end

    case (state_q)
      RUN: begin
        if (cnt_q == '0) begin
          spd_d = bus.speed;
        end
        if (bus.game_over) begin
          state_d = OVER;
          cnt_d   = '0;
          req_d   = 1'b0;
        end else if (key_is_pause) begin
          state_d = PAUSED;
        end else if (cnt_q == last_count(spd_eff)) begin
          state_d      = WAIT_ACK;
          cnt_d        = '0;
          req_d        = 1'b1;
          dir_d        = pend_q;
          pause_pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_ACK: begin
        if (bus.game_over) begin
          state_d      = OVER;
          cnt_d        = '0;
          req_d        = 1'b0;
          pause_pend_d = 1'b0;
        end else if (bus.step_ack) begin
          // A pause seen while waiting is honoured once the step completes.
          state_d      = (pause_pend_q || key_is_pause) ? PAUSED : RUN;
          req_d        = 1'b0;
          scnt_d       = scnt_q + 16'd1;
          pause_pend_d = 1'b0;
        end else if (key_is_pause) begin
          pause_pend_d = 1'b1;
        end
      end

      PAUSED: begin
        if (bus.game_over) begin
          state_d = OVER;
          cnt_d   = '0;
          req_d   = 1'b0;
        end else if (key_is_dir) begin
          state_d = RUN;
        end
      end

      OVER: begin
        req_d = 1'b0;
        cnt_d = '0;
      end

      default: begin
        state_d = OVER;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; asynchronous reset also drops an outstanding request.
  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      spd_q        <= 2'd0;
      dir_q        <= DIR_RIGHT;
      pend_q       <= DIR_RIGHT;
      req_q        <= 1'b0;
      scnt_q       <= 16'd0;
      pause_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      spd_q        <= spd_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      req_q        <= req_d;
      scnt_q       <= scnt_d;
      pause_pend_q <= pause_pend_d;
    end
  end

  assign bus.step_req   = req_q;
  assign bus.dir        = dir_q;
  assign bus.paused     = (state_q == PAUSED);
  assign bus.step_count = scnt_q;

endmodule

// File: tb/tb_move_sched.sv
// Directed bench for move_sched with TICK_BASE=4.
module tb_move_sched;

  logic clk_25M;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   hits;

  move_sched_if bus ();

  move_sched #(
    .TICK_BASE(4),
    .CNT_W    (24)
  ) dut (
    .clk_25M(clk_25M),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk_25M = 1'b0;
  always #20 clk_25M = ~clk_25M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_25M);
    #1;
  endtask

  // Apply reset with the given inputs; edge k after return is "cycle k".
  task automatic do_reset(input logic [1:0] spd, input logic [2:0] key, input logic ack);
    rst            = 1'b1;
    bus.speed      = spd;
    bus.key_stroke = key;
    bus.step_ack   = ack;
    bus.game_over  = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    #1;

    // Reset state
    do_reset(2'd3, 3'b011, 1'b1);
    chk("rst_req",   bus.step_req,   0);
    chk("rst_dir",   bus.dir,        3);
    chk("rst_pause", bus.paused,     0);
    chk("rst_count", bus.step_count, 0);

    // Fastest speed, ack tied high: request every 5 cycles
    tick(3);  chk("a_req_e3",  bus.step_req, 0);
    tick(1);  chk("a_req_e4",  bus.step_req, 1);
              chk("a_dir_e4",  bus.dir, 3);
    tick(1);  chk("a_req_e5",  bus.step_req, 0);
              chk("a_cnt_e5",  bus.step_count, 1);
    tick(3);  chk("a_req_e8",  bus.step_req, 0);
    tick(1);  chk("a_req_e9",  bus.step_req, 1);
    tick(1);  chk("a_cnt_e10", bus.step_count, 2);
    tick(4);  chk("a_req_e14", bus.step_req, 1);
    tick(1);  chk("a_cnt_e15", bus.step_count, 3);

    // Slowest speed, held request until late ack
    do_reset(2'd0, 3'b011, 1'b0);
    tick(15); chk("b_req_e15", bus.step_req, 0);
    tick(1);  chk("b_req_e16", bus.step_req, 1);
    tick(19); chk("b_req_hold", bus.step_req, 1);
              chk("b_dir_hold", bus.dir, 3);
              chk("b_cnt_hold", bus.step_count, 0);
    bus.step_ack = 1'b1;
    tick(1);  chk("b_req_ack", bus.step_req, 0);
              chk("b_cnt_ack", bus.step_count, 1);
    bus.step_ack = 1'b0;

    // Speed change mid-period only affects the following period
    do_reset(2'd3, 3'b011, 1'b1);
    tick(2);  bus.speed = 2'd0;
    tick(2);  chk("f_req_e4", bus.step_req, 1);
    tick(1);  chk("f_cnt_e5", bus.step_count, 1);
    tick(15); chk("f_req_e20", bus.step_req, 0);
    tick(1);  chk("f_req_e21", bus.step_req, 1);

    // UP then LEFT while RIGHT committed: UP survives
    do_reset(2'd3, 3'b000, 1'b0);
    tick(1);  bus.key_stroke = 3'b010;
    tick(1);  bus.key_stroke = 3'b111;
    tick(2);  chk("c_req_up", bus.step_req, 1);
              chk("c_dir_up", bus.dir, 0);
    // Asynchronous reset mid-handshake
    rst = 1'b1;
    #2;
    chk("h_req_async", bus.step_req, 0);
    chk("h_dir_async", bus.dir, 3);
    chk("h_cnt_async", bus.step_count, 0);

    // LEFT alone is a reversal and is discarded
    do_reset(2'd3, 3'b010, 1'b0);
    tick(1);  bus.key_stroke = 3'b111;
    tick(3);  chk("c_req_left", bus.step_req, 1);
              chk("c_dir_left", bus.dir, 3);

    // Pause at counter 2, resume with DOWN
    do_reset(2'd3, 3'b111, 1'b1);
    tick(2);  bus.key_stroke = 3'b100;
    tick(1);  chk("d_paused", bus.paused, 1);
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.step_req) hits++;
    end
    chk("d_no_req", hits, 0);
    chk("d_still_paused", bus.paused, 1);
    bus.key_stroke = 3'b001;
    tick(1);  chk("d_unpaused", bus.paused, 0);
    bus.key_stroke = 3'b111;
    tick(1);  chk("d_req_r1", bus.step_req, 0);
    tick(1);  chk("d_req_r2", bus.step_req, 1);
              chk("d_dir_down", bus.dir, 1);

    // Pause while waiting for ack
    do_reset(2'd3, 3'b111, 1'b0);
    tick(4);  chk("e_req", bus.step_req, 1);
    bus.key_stroke = 3'b100;
    tick(1);  bus.key_stroke = 3'b111;
    tick(3);  chk("e_req_held", bus.step_req, 1);
              chk("e_not_paused", bus.paused, 0);
    bus.step_ack = 1'b1;
    tick(1);  chk("e_req_ack", bus.step_req, 0);
              chk("e_paused", bus.paused, 1);
              chk("e_cnt", bus.step_count, 1);
    bus.step_ack = 1'b0;
    tick(5);  chk("e_paused_hold", bus.paused, 1);
              chk("e_cnt_hold", bus.step_count, 1);
    bus.game_over = 1'b1;
    tick(1);  chk("e_over_unpause", bus.paused, 0);
    bus.game_over = 1'b0;

    // Game over during handshake abandons the step permanently
    do_reset(2'd3, 3'b111, 1'b0);
    tick(4);  chk("g_req", bus.step_req, 1);
    bus.game_over = 1'b1;
    tick(1);  chk("g_req_drop", bus.step_req, 0);
              chk("g_cnt", bus.step_count, 0);
    bus.game_over  = 1'b0;
    bus.step_ack   = 1'b1;
    bus.key_stroke = 3'b001;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (bus.step_req) hits++;
    end
    chk("g_no_req", hits, 0);
    chk("g_cnt_hold", bus.step_count, 0);
    chk("g_dir_hold", bus.dir, 3);
    chk("g_not_paused", bus.paused, 0);
    do_reset(2'd3, 3'b111, 1'b1);
    tick(4);  chk("g_restart_req", bus.step_req, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
